// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M execute unit: funct3 codes, the R-type
// M-extension opcode/funct7, FSM state encoding and small op-decoding helpers.
package ex_muldiv_pkg;

  // Major opcode and funct7 that select the M extension
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

  // funct3 encodings
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_END  = 2'd2
  } state_t;

  // op1 is interpreted as signed by MULH, MULHSU, DIV and REM
  function automatic logic op1_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_MULHSU) ||
           (op == INST_DIV)  || (op == INST_REM);
  endfunction

  // op2 is interpreted as signed by MULH, DIV and REM (MULHSU keeps it unsigned)
  function automatic logic op2_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
  endfunction

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between pipeline control (master) and ex_muldiv (slave).
interface ex_muldiv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  import ex_muldiv_pkg::*;

  logic                  start_i;
  logic                  flush_i;
  logic [2:0]            op_i;
  logic [XLEN-1:0]       op1_i;
  logic [XLEN-1:0]       op2_i;
  logic [REG_ADDR_W-1:0] reg_waddr_i;
  logic [XLEN-1:0]       result_o;
  logic                  ready_o;
  logic                  busy_o;
  logic                  reg_we_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;

  modport master (
    output start_i, flush_i, op_i, op1_i, op2_i, reg_waddr_i,
    input  result_o, ready_o, busy_o, reg_we_o, reg_waddr_o
  );

  modport slave (
    input  start_i, flush_i, op_i, op1_i, op2_i, reg_waddr_i,
    output result_o, ready_o, busy_o, reg_we_o, reg_waddr_o
  );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring-division datapath on unsigned magnitudes: one quotient bit per
// enabled cycle, MSB first. After XLEN steps r_quo holds the quotient and
// r_rem the remainder.
module ex_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;

  // Trial subtraction: remainder stays below the divisor, so XLEN+1 bits hold the shifted value
  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_qbit  = ~w_diff[XLEN];
  end

  // Load operands on accept, then restore-or-keep one step per enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (load_i) begin
      r_rem <= '0;
      r_quo <= dividend_i;
      r_dvs <= divisor_i;
    end else if (en_i) begin
      r_rem <= w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_qbit};
    end
  end

  assign quotient_o  = r_quo;
  assign remainder_o = r_rem;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up at the end, start/ready handshake.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);

  localparam int                CNT_W   = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_op;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_special;
  logic [XLEN-1:0]       r_spec_res;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_mcand;

  logic                  w_accept;
  logic                  w_neg1;
  logic                  w_neg2;
  logic [XLEN-1:0]       w_mag1;
  logic [XLEN-1:0]       w_mag2;
  logic                  w_div0;
  logic                  w_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_spec_res;
  logic [XLEN:0]         w_add;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_quo;
  logic [XLEN-1:0]       w_rem;
  logic [XLEN-1:0]       w_quo_fix;
  logic [XLEN-1:0]       w_rem_fix;
  logic [XLEN-1:0]       w_final;
  logic                  w_ready;

  assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.flush_i;

  // Operand decode at accept: magnitudes (MIN negates to itself, fine as unsigned) and special divides
  always_comb begin
    w_neg1 = op1_signed(bus.op_i) & bus.op1_i[XLEN-1];
    w_neg2 = op2_signed(bus.op_i) & bus.op2_i[XLEN-1];
    w_mag1 = w_neg1 ? (~bus.op1_i + 1'b1) : bus.op1_i;
    w_mag2 = w_neg2 ? (~bus.op2_i + 1'b1) : bus.op2_i;
    w_div0 = (bus.op2_i == '0);
    w_ovf  = ((bus.op_i == INST_DIV) || (bus.op_i == INST_REM)) &&
             (bus.op1_i == MIN_VAL) && (bus.op2_i == '1);
    w_special = is_div(bus.op_i) && (w_div0 || w_ovf);
    // funct3[1] selects REM/REMU within the divide group
    if (w_div0) begin
      w_spec_res = bus.op_i[1] ? bus.op1_i : '1;
    end else begin
      w_spec_res = bus.op_i[1] ? '0 : MIN_VAL;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_special ? S_END : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_next = S_END;
      S_END:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_next = S_IDLE;
    end
  end

  // Shift-add step: add multiplicand into the high half when the current multiplier bit is set
  always_comb begin
    w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  end

  // Latch request on accept; iterate the multiplier accumulator and counter while in CALC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_waddr    <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
    end else if (w_accept) begin
      r_cnt      <= CNT_MAX;
      r_op       <= bus.op_i;
      r_neg_q    <= w_neg1 ^ w_neg2;
      r_neg_r    <= w_neg1;
      r_special  <= w_special;
      r_spec_res <= w_spec_res;
      r_waddr    <= bus.reg_waddr_i;
      r_acc      <= {{XLEN{1'b0}}, w_mag2};
      r_mcand    <= w_mag1;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      if (!is_div(r_op)) begin
        r_acc <= {w_add, r_acc[XLEN-1:1]};
      end
    end
  end

  ex_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_accept),
    .en_i       ((r_state == S_CALC) && is_div(r_op)),
    .dividend_i (w_mag1),
    .divisor_i  (w_mag2),
    .quotient_o (w_quo),
    .remainder_o(w_rem)
  );

  // Sign fix-up and result selection; only visible during the ready cycle
  always_comb begin
    w_prod    = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo_fix = r_neg_q ? (~w_quo + 1'b1) : w_quo;
    w_rem_fix = r_neg_r ? (~w_rem + 1'b1) : w_rem;
    if (r_special) begin
      w_final = r_spec_res;
    end else begin
      case (r_op)
        INST_MUL:                         w_final = w_prod[XLEN-1:0];
        INST_MULH, INST_MULHSU, INST_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
        INST_DIV, INST_DIVU:              w_final = w_quo_fix;
        default:                          w_final = w_rem_fix;
      endcase
    end
    w_ready = (r_state == S_END);
  end

  assign bus.ready_o     = w_ready;
  assign bus.reg_we_o    = w_ready;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.result_o    = w_ready ? w_final : '0;
  assign bus.reg_waddr_o = w_ready ? r_waddr : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table through a scoreboard,
// plus hand sequences for flush, held start, reset abort and XLEN=16.
`timescale 1ns/1ps
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  ex_muldiv_if #(.XLEN(16), .REG_ADDR_W(5)) bus16 ();

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ex_muldiv #(.XLEN(16), .REG_ADDR_W(5)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  waddr;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'(bus.result_o), 64'h1_0000_0000);
      end else begin
        mon_e = sb.pop_front();
        $display("txn accept=%0d latency=%0d result=%h waddr=%0d we=%0d",
                 mon_e.acc, cyc - mon_e.acc, bus.result_o, bus.reg_waddr_o, bus.reg_we_o);
        check("result", 64'(bus.result_o), 64'(mon_e.res));
        check("waddr", 64'(bus.reg_waddr_o), 64'(mon_e.waddr));
        check("reg_we", 64'(bus.reg_we_o), 64'd1);
        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  // Drive one request for one cycle; caller is at a negedge in an IDLE cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.op1_i = a;
    bus.op2_i = b;
    bus.reg_waddr_i = wa;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Bounded wait for all outstanding results, then one cycle for END->IDLE
  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.waddr = v.wa;
    e.acc = cyc;
    e.lat = v.lat;
    sb.push_back(e);
    issue(v.op, v.a, v.b, v.wa);
    check("busy_after_accept", 64'(bus.busy_o), 64'd1);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 1ms", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    int k;
    exp_t e;

    vecs[0]  = '{INST_DIVU,   32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{INST_REMU,   32'd100,        32'd7,          5'd5,  32'd2,          33};
    vecs[2]  = '{INST_DIV,    32'hFFFFFFF9,   32'd2,          5'd1,  32'hFFFFFFFD,   33};
    vecs[3]  = '{INST_REM,    32'hFFFFFFF9,   32'd2,          5'd2,  32'hFFFFFFFF,   33};
    vecs[4]  = '{INST_MULH,   32'h80000000,   32'h80000000,   5'd3,  32'h40000000,   33};
    vecs[5]  = '{INST_MUL,    32'hFFFFFFFF,   32'd2,          5'd4,  32'hFFFFFFFE,   33};
    vecs[6]  = '{INST_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd6,  32'hFFFFFFFF,   33};
    vecs[7]  = '{INST_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   5'd7,  32'hFFFFFFFE,   33};
    vecs[8]  = '{INST_DIV,    32'd5,          32'd0,          5'd8,  32'hFFFFFFFF,   1};
    vecs[9]  = '{INST_REMU,   32'd5,          32'd0,          5'd9,  32'd5,          1};
    vecs[10] = '{INST_DIV,    32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000,   1};
    vecs[11] = '{INST_REM,    32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          1};
    vecs[12] = '{INST_DIV,    32'hFFFFFF9C,   32'd7,          5'd12, 32'hFFFFFFF2,   33};
    vecs[13] = '{INST_REM,    32'hFFFFFF9C,   32'd7,          5'd13, 32'hFFFFFFFE,   33};
    vecs[14] = '{INST_MUL,    32'h12345678,   32'd9,          5'd14, 32'hA3D70A38,   33};
    vecs[15] = '{INST_MULH,   32'hFFFFFFFD,   32'd5,          5'd15, 32'hFFFFFFFF,   33};
    vecs[16] = '{INST_REMU,   32'hFFFFFFFF,   32'd10,         5'd16, 32'd5,          33};
    vecs[17] = '{INST_DIV,    32'd7,          32'hFFFFFFFE,   5'd17, 32'hFFFFFFFD,   33};
    vecs[18] = '{INST_REM,    32'd7,          32'hFFFFFFFE,   5'd18, 32'd1,          33};
    vecs[19] = '{INST_MULHU,  32'h80000000,   32'd4,          5'd19, 32'd2,          33};

    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0;
    bus.op1_i = '0; bus.op2_i = '0; bus.reg_waddr_i = '0;
    bus16.start_i = 1'b0; bus16.flush_i = 1'b0; bus16.op_i = '0;
    bus16.op1_i = '0; bus16.op2_i = '0; bus16.reg_waddr_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.result_o, bus.ready_o, bus.busy_o, bus.reg_we_o, bus.reg_waddr_o}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table
    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i]);
    end

    // Flush at cycle 10 of a DIV: busy drops in cycle 11, no ready ever
    c0 = cyc;
    issue(INST_DIV, 32'd1000, 32'd3, 5'd7);
    while (cyc < c0 + 10) @(negedge clk);
    check("busy_before_flush", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("busy_after_flush", 64'(bus.busy_o), 64'd0);
    check("ready_after_flush", 64'(bus.ready_o), 64'd0);
    repeat (40) @(negedge clk);
    run_vec('{INST_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE, 33});

    // start together with flush in IDLE: nothing accepted
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    bus.op_i = INST_DIVU; bus.op1_i = 32'd9; bus.op2_i = 32'd3; bus.reg_waddr_i = 5'd22;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("start_flush_no_accept", 64'(bus.busy_o), 64'd0);
    repeat (40) @(negedge clk);

    // start held high: accepts at cycle 0 and 34 only
    c0 = cyc;
    e.res = 32'hFFFFFFFE; e.waddr = 5'd23; e.lat = 33;
    e.acc = c0;
    sb.push_back(e);
    e.acc = c0 + 34;
    sb.push_back(e);
    bus.start_i = 1'b1;
    bus.op_i = INST_MULHU; bus.op1_i = 32'hFFFFFFFF; bus.op2_i = 32'hFFFFFFFF; bus.reg_waddr_i = 5'd23;
    while (cyc < c0 + 33) @(negedge clk);
    check("held_busy_in_end", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    check("held_idle_gap", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    check("held_second_accept", 64'(bus.busy_o), 64'd1);
    while (cyc < c0 + 50) @(negedge clk);
    bus.start_i = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("held_no_third", 64'(sb.size()), 64'd0);

    // Reset asserted at cycle 15 of a MUL aborts immediately
    c0 = cyc;
    issue(INST_MUL, 32'd3, 32'd5, 5'd24);
    while (cyc < c0 + 15) @(negedge clk);
    check("busy_before_rst", 64'(bus.busy_o), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_outputs", 64'({bus.result_o, bus.ready_o, bus.busy_o, bus.reg_we_o, bus.reg_waddr_o}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_idle_after_release", 64'(bus.busy_o), 64'd0);

    // XLEN=16: signed overflow special case ready in cycle 1
    bus16.start_i = 1'b1;
    bus16.op_i = INST_DIV; bus16.op1_i = 16'h8000; bus16.op2_i = 16'hFFFF; bus16.reg_waddr_i = 5'd4;
    @(negedge clk);
    bus16.start_i = 1'b0;
    check("x16_ovf_ready", 64'(bus16.ready_o), 64'd1);
    check("x16_ovf_result", 64'(bus16.result_o), 64'h8000);
    check("x16_ovf_waddr", 64'(bus16.reg_waddr_o), 64'd4);
    $display("txn x16 DIV 8000/FFFF result=%h ready=%0d", bus16.result_o, bus16.ready_o);
    repeat (2) @(negedge clk);

    // XLEN=16: normal DIVU 1000/3 = 333, ready in cycle 17
    c0 = cyc;
    bus16.start_i = 1'b1;
    bus16.op_i = INST_DIVU; bus16.op1_i = 16'd1000; bus16.op2_i = 16'd3; bus16.reg_waddr_i = 5'd6;
    @(negedge clk);
    bus16.start_i = 1'b0;
    k = 0;
    while (bus16.ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("x16_divu_latency", 64'(cyc - c0), 64'd17);
    check("x16_divu_result", 64'(bus16.result_o), 64'd333);
    $display("txn x16 DIVU 1000/3 result=%h latency=%0d", bus16.result_o, cyc - c0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised multi-cycle RV32M execute unit, the next generation of the execute stage. It runs MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU iteratively (radix-2, one bit per cycle) with a start/ready handshake. It sits beside the combinational ALU in the execute stage. The pipeline control stalls while busy_o is high and writes result_o to reg_waddr_o when reg_we_o pulses.

Parameters:
XLEN, 32, operand/result width (must be even, >=8)
REG_ADDR_W, 5, destination register address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
flush_i  input  1  abort current operation (pipeline flush/jump)
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  input  XLEN  rs1 value (multiplicand/dividend)
op2_i  input  XLEN  rs2 value (multiplier/divisor)
reg_waddr_i  input  REG_ADDR_W  destination register
result_o  output  XLEN  result, valid only while ready_o=1
ready_o  output  1  one-cycle completion pulse
busy_o  output  1  high from the cycle after accept until the ready cycle inclusive
reg_we_o  output  1  equals ready_o
reg_waddr_o  output  REG_ADDR_W  latched destination, valid with ready_o

Behaviour:
- Reset (rst=0, async): state=IDLE; result_o=0, ready_o=0, busy_o=0, reg_we_o=0, reg_waddr_o=0; all internal registers are cleared.
- States: IDLE, CALC, END.
- IDLE: if start_i=1 and flush_i=0, latch op_i, the operands and reg_waddr_i. Go to END for the special division cases, otherwise to CALC with the counter set to XLEN-1.
- CALC: one iteration per cycle. Go to END when the counter reaches 0. CALC always lasts exactly XLEN cycles.
- END: drive ready_o=1 and the final result for one cycle, then go to IDLE. A start_i seen in END is ignored; a new request is accepted in IDLE only, so the minimum issue spacing is XLEN+2 cycles.
- Latency: accept edge = cycle 0. Normal operation has ready_o high in cycle XLEN+1. Special division cases have ready_o high in cycle 1.
- Signed handling: take magnitudes of the signed operands at accept. MULHSU treats op1 as signed and op2 as unsigned.
  - Multiply: shift-add of magnitudes into a 2*XLEN accumulator; negate the product if the operand signs differ.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide: restoring division on magnitudes. Quotient sign = sign(op1)^sign(op2); remainder sign = sign(op1).
- Special cases, decided at accept, no CALC:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1=MIN, op2=-1): DIV returns MIN; REM returns 0.
- Any signed negative operand is handled. XLEN-bit negation of MIN wraps to MIN, which is correct as an unsigned magnitude.
- flush_i=1 in any state: next state IDLE, ready_o and reg_we_o stay 0 that cycle and after, busy_o drops next cycle. If flush_i and start_i are both 1 in IDLE, flush wins and nothing is accepted. If flush_i=1 in END, it does not suppress the current ready pulse; the result is already committed.
- Asserting rst mid-operation aborts immediately; after release the unit is IDLE with no pending result.
- result_o holds 0 outside the ready cycle, so downstream never sees a stale value.

Decomposition:
- The shared defines file gets the funct3 constants INST_MUL…INST_REMU, the opcode INST_TYPE_R_M (0110011, funct7=0000001), and the state encodings.
- One natural sub-module: ex_div_iter, the restoring-division datapath (remainder/quotient registers, one step per enable), with the same clk/rst.
- The multiplier accumulator, sign fix-up and FSM stay in ex_muldiv.

Test Plan:
- DIVU 100/7 -> ready_o in cycle 33, result 14; REMU 100/7 -> 2; reg_waddr_o=5 echoed with reg_we_o=1.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; MULH 0x80000000*0x80000000 -> 0x40000000; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all four with ready_o in cycle 1.
- flush_i at cycle 10 of a DIV -> busy_o=0 from cycle 11, no ready_o; next MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE at cycle 33 of its own accept.
- start_i held high continuously -> one accept per 34 cycles, no double issue; start_i with flush_i in IDLE -> no accept.
- rst low at cycle 15 of a MUL -> outputs 0 immediately, no ready_o after release; a parameter sweep at XLEN=16 checks 0x8000/0xFFFF -> 0x8000 in cycle 1.
